// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline hazard sources/consumers and pipe_ctrl.
// Optional perf counters appear only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if #(
  parameter int MC_CNT_W = 6,
  parameter int PC_W     = 32
);
  logic                stallreq_id;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_len;
  logic                id_branch_flush;
  logic                excp_req;
  logic [PC_W-1:0]     excp_pc;

  logic [5:0]          stall;
  logic                flush;
  logic                flush_ifid;
  logic [PC_W-1:0]     new_pc;
  logic                mc_busy;
  logic                mc_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]         stall_cycles;
  logic [15:0]         flush_count;
`endif

  modport master (
    output stallreq_id, ex_mc_start, ex_mc_len, id_branch_flush, excp_req, excp_pc,
    input  stall, flush, flush_ifid, new_pc, mc_busy, mc_done
`ifdef PIPE_CTRL_PERF_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  stallreq_id, ex_mc_start, ex_mc_len, id_branch_flush, excp_req, excp_pc,
    output stall, flush, flush_ifid, new_pc, mc_busy, mc_done
`ifdef PIPE_CTRL_PERF_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall vector, flushes, EX multi-cycle freeze.
// Optional stall/flush statistics counters are enabled with `define PIPE_CTRL_PERF_EN.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_RUN     | normal flow; ID stalls and branch squashes are honoured
//   ST_MC_WAIT | EX multi-cycle op in flight; pc..ex frozen until cnt hits 1
module pipe_ctrl #(
  parameter int MC_CNT_W = 6,
  parameter int PC_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  localparam logic [5:0]          STALL_ID = 6'b000111;
  localparam logic [5:0]          STALL_EX = 6'b001111;
  localparam logic [MC_CNT_W-1:0] CNT_ONE  = MC_CNT_W'(1);

  state_t              state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic [MC_CNT_W-1:0] len_eff;

  logic [5:0]          stall_o;
  logic                flush_o;
  logic                flush_ifid_o;
  logic [PC_W-1:0]     new_pc_o;
  logic                mc_done_o;

  // Priority: exception > multi-cycle (in flight or starting) > ID stall > branch squash.
  always_comb begin
    len_eff      = (bus.ex_mc_len == '0) ? CNT_ONE : bus.ex_mc_len;
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_o      = '0;
    flush_o      = 1'b0;
    flush_ifid_o = 1'b0;
    new_pc_o     = '0;
    mc_done_o    = 1'b0;

    if (rst) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (bus.excp_req) begin
      flush_o  = 1'b1;
      new_pc_o = bus.excp_pc;
      state_d  = ST_RUN;
      cnt_d    = '0;
    end else if (state_q == ST_MC_WAIT) begin
      stall_o = STALL_EX;
      if (cnt_q <= CNT_ONE) begin
        mc_done_o = 1'b1;
        state_d   = ST_RUN;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (bus.ex_mc_start) begin
      stall_o = STALL_EX;
      if (len_eff == CNT_ONE) begin
        mc_done_o = 1'b1;
      end else begin
        cnt_d   = len_eff - CNT_ONE;
        state_d = ST_MC_WAIT;
      end
    end else if (bus.stallreq_id) begin
      stall_o = STALL_ID;
    end else if (bus.id_branch_flush) begin
      flush_ifid_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall      = stall_o;
  assign bus.flush      = flush_o;
  assign bus.flush_ifid = flush_ifid_o;
  assign bus.new_pc     = new_pc_o;
  assign bus.mc_done    = mc_done_o;
  // State may still read MC_WAIT during the reset cycle; outputs must already be quiet.
  assign bus.mc_busy    = !rst && (state_q == ST_MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, (stall_o != '0)};
    flush_count_d  = flush_count_q + {15'd0, flush_o};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

endmodule
